// File: rtl/aes_pkg.sv
// Shared AES definitions for the cipher core.
// Contents: block/round widths, the FSM encoding, the forward S-box table,
// the key-size -> round-count mapping, and the byte/column transforms used by
// the round datapath. Byte k of a block sits at bits [127-8k -: 8] and
// column c holds bytes 4c..4c+3, with the row running inside the column.
package aes_pkg;

    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned ROUND_W = 5;

    typedef logic [BLOCK_W-1:0] state_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round count for a key length; 0 flags an illegal key length.
    function automatic int unsigned nr_of(input int unsigned key_size);
        case (key_size)
            128:     return 10;
            192:     return 12;
            256:     return 14;
            default: return 0;
        endcase
    endfunction

    // Entry b lives at bits [(255-b)*8+7 -: 8], i.e. index {~b, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic state_t sub_bytes(input state_t s);
        state_t r;
        for (int unsigned k = 0; k < 16; k++) begin
            r[8*k +: 8] = sbox(s[8*k +: 8]);
        end
        return r;
    endfunction

    // Row r of the output takes column (c + r) mod 4 of the input.
    function automatic state_t shift_rows(input state_t s);
        state_t     r;
        logic [3:0] dst;
        logic [3:0] src;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned row = 0; row < 4; row++) begin
                dst = 4'(4*c + row);
                src = 4'(4*((c + row) % 4) + row);
                r[{~dst, 3'b111} -: 8] = s[{~src, 3'b111} -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic state_t mix_columns(input state_t s);
        state_t     r;
        logic [1:0] ci;
        for (int unsigned c = 0; c < 4; c++) begin
            ci = 2'(c);
            r[{~ci, 5'b11111} -: 32] = mix_column(s[{~ci, 5'b11111} -: 32]);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lookup for one byte.
// Ports: byte_in - input byte; byte_out_c - substituted byte (combinational).
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] byte_in,
    output logic [7:0] byte_out_c
);

    assign byte_out_c = sbox(byte_in);

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES encryption core, one round per clock.
// Ports:
//   clk, reset              - clock and asynchronous active-high reset
//   key_ready               - upstream key schedule is valid
//   in_valid / in_ready     - plaintext handshake (in_ready is combinational)
//   plaintext               - 128-bit input block
//   round                   - round index whose key is requested (0..NR)
//   round_key               - key for `round`, same cycle from upstream
//   out_valid               - one-cycle completion pulse
//   ciphertext              - result, held until the next completion
module aes_cipher_core
    import aes_pkg::*;
#(
    parameter int unsigned key_size = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key_ready,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BLOCK_W-1:0]   plaintext,
    output logic [ROUND_W-1:0]   round,
    input  logic [BLOCK_W-1:0]   round_key,
    output logic                 out_valid,
    output logic [BLOCK_W-1:0]   ciphertext
);

    localparam int unsigned         NR         = nr_of(key_size);
    localparam logic [ROUND_W-1:0]  LAST_ROUND = ROUND_W'(NR);

    if (NR == 0) begin : g_bad_key_size
        $error("aes_cipher_core: key_size must be 128, 192 or 256");
    end

    fsm_t               fsm_q, fsm_d;
    logic [ROUND_W-1:0] round_q, round_d;
    state_t             state_reg_q, state_reg_d;
    state_t             ciphertext_q, ciphertext_d;
    logic               out_valid_q, out_valid_d;

    state_t             sub_out;
    state_t             shifted;
    state_t             mixed;

    // SubBytes on the current state, one lookup per byte.
    for (genvar g = 0; g < 16; g++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_in    (state_reg_q[8*g +: 8]),
            .byte_out_c (sub_out[8*g +: 8])
        );
    end

    assign shifted = shift_rows(sub_out);
    assign mixed   = mix_columns(shifted);

    // Idle with a valid schedule is the only accepting condition; held low in reset.
    assign in_ready = (fsm_q == ST_IDLE) && key_ready && !reset;

    // Next-state and round datapath.
    always_comb begin
        fsm_d        = fsm_q;
        round_d      = round_q;
        state_reg_d  = state_reg_q;
        ciphertext_d = ciphertext_q;
        out_valid_d  = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    state_reg_d = plaintext ^ round_key;
                    round_d     = ROUND_W'(1);
                    fsm_d       = ST_RUN;
                end
            end
            ST_RUN: begin
                if (round_q == LAST_ROUND) begin
                    // Final round skips MixColumns.
                    ciphertext_d = shifted ^ round_key;
                    out_valid_d  = 1'b1;
                    round_d      = '0;
                    fsm_d        = ST_IDLE;
                end else begin
                    state_reg_d = mixed ^ round_key;
                    round_d     = round_q + ROUND_W'(1);
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q        <= ST_IDLE;
            round_q      <= '0;
            state_reg_q  <= '0;
            ciphertext_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            round_q      <= round_d;
            state_reg_q  <= state_reg_d;
            ciphertext_q <= ciphertext_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign round      = round_q;
    assign out_valid  = out_valid_q;
    assign ciphertext = ciphertext_q;

endmodule

// File: tb/tb_aes_cipher_core.sv
// Bench for aes_cipher_core: AES-128 and AES-256 instances, FIPS-197 known
// answers plus random blocks against a matrix-level reference model with
// its own S-box derived from GF(2^8) inverses.
module tb_aes_cipher_core;

    localparam int NR0 = 10;
    localparam int NR1 = 14;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        key_ready;
    logic [1:0]        in_valid;
    logic [1:0]        in_ready;
    logic [1:0][127:0] plaintext;
    logic [1:0][4:0]   round;
    logic [1:0][127:0] round_key;
    logic [1:0]        out_valid;
    logic [1:0][127:0] ciphertext;

    logic [127:0] sched [2][15];
    logic [7:0]   ref_sbox [256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aes_cipher_core #(.key_size(128)) u_dut128 (
        .clk(clk), .reset(reset), .key_ready(key_ready[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .plaintext(plaintext[0]),
        .round(round[0]), .round_key(round_key[0]),
        .out_valid(out_valid[0]), .ciphertext(ciphertext[0])
    );

    aes_cipher_core #(.key_size(256)) u_dut256 (
        .clk(clk), .reset(reset), .key_ready(key_ready[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .plaintext(plaintext[1]),
        .round(round[1]), .round_key(round_key[1]),
        .out_valid(out_valid[1]), .ciphertext(ciphertext[1])
    );

    // Upstream key stage: key for the requested round, same cycle.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            round_key[d] = (round[d] < 5'd15) ? sched[d][4'(round[d])] : '0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box = affine transform of the multiplicative inverse.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (a != 0 && gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            ref_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]};
    endfunction

    // Key expansion; key is left-aligned in 256 bits, nk = 4 or 8 words.
    task automatic expand_key(input int d, input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int          nr;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gf_mul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 15; r++) begin
            sched[d][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
        end
    endtask

    function automatic logic [127:0] ref_encrypt(input int d, input logic [127:0] pt, input int nr);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] k;
        logic [127:0] res;
        k = sched[d][0];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = pt[127 - 8*(4*c + r) -: 8] ^ k[127 - 8*(4*c + r) -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = ref_sbox[s[r][(c + r) % 4]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] = (rnd < nr) ? (gf_mul(8'h02, t[r][c]) ^ gf_mul(8'h03, t[(r+1)%4][c])
                                            ^ t[(r+2)%4][c] ^ t[(r+3)%4][c])
                                         : t[r][c];
            k = sched[d][rnd];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] = s[r][c] ^ k[127 - 8*(4*c + r) -: 8];
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                res[127 - 8*(4*c + r) -: 8] = s[r][c];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Present a block and wait (bounded) until the core will take it next edge.
    task automatic offer(input int d, input logic [127:0] pt, input string tag);
        bit ok;
        ok = 1'b0;
        plaintext[d] = pt;
        in_valid[d]  = 1'b1;
        #1;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (in_ready[d]) ok = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        chk({tag, "_accept"}, 128'(ok), 128'd1);
    endtask

    // Follow an accepted block to completion and check latency and result.
    task automatic wait_result(input int d, input logic [127:0] exp, input int nr, input string tag,
                               input bit keep, input logic [127:0] next_pt, input bit drop_kr);
        int lat;
        bit leak;
        lat  = -1;
        leak = 1'b0;
        for (int k = 1; k <= nr + 5 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (keep) plaintext[d] = next_pt;
                else      in_valid[d]  = 1'b0;
            end
            if (drop_kr && k == 2) key_ready[d] = 1'b0;
            #1;
            if (out_valid[d]) lat = k - 1;
            else if (in_ready[d]) leak = 1'b1;
        end
        chk({tag, "_latency"}, 128'(lat), 128'(nr));
        chk({tag, "_ready_low_in_run"}, 128'(leak), 128'd0);
        chk({tag, "_ciphertext"}, ciphertext[d], exp);
        chk({tag, "_ready_at_done"}, 128'(in_ready[d]), 128'(key_ready[d]));
        if (drop_kr) key_ready[d] = 1'b1;
    endtask

    // Round sequencing and single-cycle out_valid on both instances.
    logic [4:0] prev_round [2];
    bit         prev_ov    [2];
    initial begin
        prev_round = '{5'd0, 5'd0};
        prev_ov    = '{1'b0, 1'b0};
    end
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                prev_round[d] = 5'd0;
                prev_ov[d]    = 1'b0;
            end else begin
                int nr;
                nr = (d == 0) ? NR0 : NR1;
                chk("round_max", 128'(round[d] <= 5'(nr)), 128'd1);
                if (prev_round[d] != 5'd0)
                    chk("round_seq", 128'(round[d]),
                        (int'(prev_round[d]) == nr) ? 128'd0 : 128'(prev_round[d] + 5'd1));
                if (prev_ov[d]) chk("out_valid_pulse", 128'(out_valid[d]), 128'd0);
                prev_round[d] = round[d];
                prev_ov[d]    = out_valid[d];
            end
        end
    end

    initial begin
        logic [127:0] p1, p2, e1, e2;
        bit           seen;

        reset     = 1'b1;
        key_ready = 2'b11;
        in_valid  = 2'b00;
        plaintext = '0;
        build_sbox();

        // Reset state.
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_round", 128'(round[d]), 128'd0);
            chk("reset_out_valid", 128'(out_valid[d]), 128'd0);
            chk("reset_ciphertext", ciphertext[d], 128'd0);
            chk("reset_in_ready", 128'(in_ready[d]), 128'd0);
        end
        reset = 1'b0;

        // FIPS-197 Appendix B.
        expand_key(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
        offer(0, 128'h3243f6a8885a308d313198a2e0370734, "appb");
        wait_result(0, 128'h3925841d02dc09fbdc118597196a0b32, NR0, "appb", 1'b0, '0, 1'b0);

        // Appendix C.1 and C.3.
        expand_key(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        offer(0, 128'h00112233445566778899aabbccddeeff, "c1");
        wait_result(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, NR0, "c1", 1'b0, '0, 1'b0);
        expand_key(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
        offer(1, 128'h00112233445566778899aabbccddeeff, "c3");
        wait_result(1, 128'h8ea2b7ca516745bfeafc49904b496089, NR1, "c3", 1'b0, '0, 1'b0);

        // Back-to-back with in_valid held high.
        p1 = rand128();
        p2 = rand128();
        e1 = ref_encrypt(0, p1, NR0);
        e2 = ref_encrypt(0, p2, NR0);
        offer(0, p1, "b2b1");
        wait_result(0, e1, NR0, "b2b1", 1'b1, p2, 1'b0);
        wait_result(0, e2, NR0, "b2b2", 1'b0, '0, 1'b0);

        // Flow control: no accept while key_ready is low.
        @(negedge clk);
        key_ready[0] = 1'b0;
        plaintext[0] = p1;
        in_valid[0]  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("fc_in_ready", 128'(in_ready[0]), 128'd0);
            chk("fc_round", 128'(round[0]), 128'd0);
        end
        key_ready[0] = 1'b1;
        #1;
        chk("fc_ready_rise", 128'(in_ready[0]), 128'd1);
        wait_result(0, e1, NR0, "fc", 1'b0, '0, 1'b0);

        // Reset in the middle of a block.
        expand_key(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
        offer(0, 128'h3243f6a8885a308d313198a2e0370734, "rst_blk");
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) in_valid[0] = 1'b0;
            #1;
            if (round[0] == 5'd5) seen = 1'b1;
        end
        chk("rst_reach_round5", 128'(seen), 128'd1);
        reset = 1'b1;
        #1;
        chk("rst_out_valid", 128'(out_valid[0]), 128'd0);
        chk("rst_ciphertext", ciphertext[0], 128'd0);
        chk("rst_round", 128'(round[0]), 128'd0);
        chk("rst_in_ready", 128'(in_ready[0]), 128'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            if (out_valid[0]) seen = 1'b1;
        end
        chk("rst_no_out_valid", 128'(seen), 128'd0);
        offer(0, 128'h3243f6a8885a308d313198a2e0370734, "appb_after_rst");
        wait_result(0, 128'h3925841d02dc09fbdc118597196a0b32, NR0, "appb_after_rst", 1'b0, '0, 1'b0);

        // Random keys and blocks; one AES-256 block drops key_ready mid-run.
        for (int i = 0; i < 4; i++) begin
            expand_key(0, {rand128(), 128'h0}, 4);
            p1 = rand128();
            offer(0, p1, "rand128");
            wait_result(0, ref_encrypt(0, p1, NR0), NR0, "rand128", 1'b0, '0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            expand_key(1, {rand128(), rand128()}, 8);
            p1 = rand128();
            offer(1, p1, "rand256");
            wait_result(1, ref_encrypt(1, p1, NR1), NR1, "rand256", 1'b0, '0, i == 1);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_cipher_core.md
Name: aes_cipher_core

Overview:
- Iterative AES encryption datapath, one round per clock; consumes round keys produced by the key-expansion stage, which sits directly upstream.
- Drives `round` to the key-expansion stage and receives the matching `round_key` in the same cycle.
- Accepts one plaintext block at a time and returns the ciphertext with a single-cycle valid pulse.
- Sits inside aes_top between the plaintext input and the ciphertext output.

Parameters:
- key_size, 128, AES key length; legal values 128/192/256. Sets NR = 10/12/14. Any other value is a compile-time error.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- key_ready  input  1  key-expansion stage has a valid schedule; `round_key` is valid for `round`.
- in_valid  input  1  plaintext offered.
- in_ready  output  1  core can accept a block this cycle.
- plaintext  input  128  block; byte 0 = bits [127:120], column-major per FIPS-197.
- round  output  5  round index whose key is requested (0..NR).
- round_key  input  128  key for `round`, combinational from upstream, same cycle.
- out_valid  output  1  one-cycle pulse, ciphertext valid.
- ciphertext  output  128  result, held until next completion.

Behaviour:
- Reset is asynchronous and active-high, on one clock. While reset is asserted:
  - state = IDLE, round = 0, state register = 0.
  - ciphertext = 0, out_valid = 0, in_ready = 0.
- FSM has two states: IDLE and RUN.
- IDLE:
  - round = 0.
  - in_ready = key_ready.
  - On a clock edge with in_valid && in_ready: state_reg <= plaintext ^ round_key (initial AddRoundKey), round <= 1, go to RUN.
- RUN, round r with 1 <= r < NR:
  - state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ round_key.
  - round <= r+1.
  - in_ready = 0.
- RUN, round r = NR:
  - ciphertext <= ShiftRows(SubBytes(state_reg)) ^ round_key (no MixColumns).
  - out_valid <= 1 for exactly one cycle.
  - round <= 0, go to IDLE.
- Latency: if a block is accepted at edge E0, ciphertext and out_valid are visible after edge E0+NR (10 cycles for AES-128).
- Throughput: one block per NR+1 cycles. in_ready may rise in the same cycle out_valid is high, so a back-to-back accept is legal.
- in_valid while in_ready = 0 is ignored. No buffering; the source must hold its data.
- key_ready dropping during RUN does not abort the block. The upstream stage must keep round_key correct for the presented round; this is a protocol violation the bench checks.
- ciphertext holds its last value; it updates only on completion.
- Reset mid-block: the block is discarded, no out_valid, all outputs return to reset values immediately.
- MixColumns arithmetic:
  - GF(2^8) with polynomial 0x11B.
  - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00).
  - Column output is 2·a0^3·a1^a2^a3 with rotations; all arithmetic is 8-bit.
- round width is 5 bits; max value 14 for AES-256. Upper values are never produced.

Decomposition:
- Package aes_pkg:
  - function nr_of(key_size).
  - typedef state_t = logic [127:0].
  - S-box constant (256×8).
  - functions xtime, sub_bytes, shift_rows, mix_columns.
- Sub-module aes_sbox: combinational byte lookup, instantiated 16×.
- Round logic stays inline in aes_cipher_core.

Test Plan:
- Known answer, FIPS-197 App. B: key_size=128, key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32 with out_valid exactly 10 cycles after accept. The bench model supplies round keys.
- Known answer, App. C.1 and C.3:
  - plaintext 00112233445566778899aabbccddeeff, key 000102..0f -> 69c4e0d86a7b0430d8cdb78070b4c55a.
  - key_size=256, key 000102..1f -> 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
- Back-to-back: in_valid held high with two blocks -> second accepted in the cycle out_valid of the first is high; both results correct; in_ready low during each RUN.
- Flow control: key_ready=0 with in_valid=1 for 5 cycles -> no accept, round stays 0. Raise key_ready -> accept next edge.
- Reset mid-operation: assert reset at round 5 -> outputs immediately zero, no out_valid. Release reset and resend the App. B block -> correct ciphertext.
- Round sequencing: monitor `round` -> strictly 0,1,…,NR,0 per block; never exceeds NR; out_valid never high for two consecutive cycles.
